controlador_mem: RTL and testbench

Bus-master controller that drives the CPUCR main-memory bus (Direccion, Datos, LE) on behalf of the CPU core. It turns a single-cycle CPU request (read or write, address, write data) into a correctly sequenced bus cycle with programmable wait states. It returns a one-cycle acknowledge, and read data for reads. It is the initiator end of the memory interface: the memory is passive, drives Datos whenever LE=1, and captures Datos into M[Direccion] on the falling edge of LE.

---
 rtl/controlador_mem.sv | 116 +++++++++++
 tb/tb_controlador_mem.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_mem.sv
`default_nettype none
// controlador_mem: CPUCR main-memory bus master. Turns single-cycle CPU requests
// into sequenced Direccion/Datos/LE bus cycles with WAIT_CYCLES wait states.
module controlador_mem #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_wdata,
  output logic [7:0]  o_rdata,
  output logic        o_ack,
  output logic        o_busy,
  output logic [15:0] o_direccion,
  inout  wire  [7:0]  io_datos,
  output logic        o_le
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_STB  = 3'd3,
    S_RECOV   = 3'd4
  } state_t;

  localparam logic [3:0] C_CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [15:0] r_dir;
  logic [7:0]  r_wdata;
  logic        r_we;
  logic [7:0]  r_rdata;
  logic        r_ack;
  logic        r_busy;
  logic        r_le;

  // LE itself is the tri-state enable, so the bus is released the instant LE
  // returns high, including on an asynchronous reset.
  assign io_datos    = r_le ? 8'hzz : r_wdata;
  assign o_direccion = r_dir;
  assign o_le        = r_le;
  assign o_rdata     = r_rdata;
  assign o_ack       = r_ack;
  assign o_busy      = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_dir   <= 16'h0000;
      r_wdata <= 8'h00;
      r_we    <= 1'b0;
      r_rdata <= 8'h00;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_le    <= 1'b1;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_dir   <= i_addr;
            r_wdata <= i_wdata;
            r_we    <= i_we;
            r_busy  <= 1'b1;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_cnt <= C_CNT_INIT;
          if (r_we) begin
            r_le    <= 1'b0;
            r_state <= S_WR_STB;
          end else begin
            r_state <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rdata <= io_datos;
            r_ack   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_WR_STB: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_le    <= 1'b1;
            r_state <= S_RECOV;
          end
        end
        S_RECOV: begin
          // Address held one more cycle past the LE rise before completing.
          r_ack   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_le    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_controlador_mem.sv
`default_nettype none
// tb_controlador_mem: scoreboard bench for controlador_mem with W=1 and W=3
// instances, each attached to a passive memory model on its own bus.
module tb_controlador_mem;

  localparam int W0 = 1;
  localparam int W1 = 3;

  typedef struct {
    bit         rd;
    logic [7:0] data;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;

  logic        req   [2];
  logic        we    [2];
  logic [15:0] addr  [2];
  logic [7:0]  wdata [2];
  logic [7:0]  rdata [2];
  logic        ack   [2];
  logic        busy  [2];
  logic [15:0] dir   [2];
  logic        le    [2];
  wire  [7:0]  datos0;
  wire  [7:0]  datos1;

  logic [7:0]  mem   [2][65536];
  logic [7:0]  model [2][65536];

  exp_t q0[$];
  exp_t q1[$];

  bit          have_cur [2];
  logic [15:0] cur_addr [2];
  bit          cur_we   [2];
  logic [7:0]  cur_wd   [2];
  int          lo_run   [2];
  int          last_e0  [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  controlador_mem #(.WAIT_CYCLES(W0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_req(req[0]), .i_we(we[0]), .i_addr(addr[0]),
    .i_wdata(wdata[0]), .o_rdata(rdata[0]), .o_ack(ack[0]), .o_busy(busy[0]),
    .o_direccion(dir[0]), .io_datos(datos0), .o_le(le[0])
  );

  controlador_mem #(.WAIT_CYCLES(W1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_req(req[1]), .i_we(we[1]), .i_addr(addr[1]),
    .i_wdata(wdata[1]), .o_rdata(rdata[1]), .o_ack(ack[1]), .o_busy(busy[1]),
    .o_direccion(dir[1]), .io_datos(datos1), .o_le(le[1])
  );

  // Passive memory: drives the bus while LE=1, captures on LE fall.
  assign datos0 = le[0] ? mem[0][dir[0]] : 8'hzz;
  assign datos1 = le[1] ? mem[1][dir[1]] : 8'hzz;
  always @(negedge le[0]) begin #1; mem[0][dir[0]] = datos0; end
  always @(negedge le[1]) begin #1; mem[1][dir[1]] = datos1; end

  function automatic int wof(input int k);
    return (k == 0) ? W0 : W1;
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  task automatic chk(input bit ok, input string name, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s k=%0d got=%0h exp=%0h t=%0t", name, k, act, exp, $time);
    end
  endtask

  task automatic monitor_step(input int k);
    exp_t       e;
    logic [7:0] dv;
    dv = (k == 0) ? datos0 : datos1;
    if (ack[k]) begin
      if (qsize(k) == 0) begin
        chk(1'b0, "ack_unexpected", k, 32'd1, 32'd0);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk(cyc == e.due, "ack_latency", k, cyc, e.due);
        if (e.rd) chk(rdata[k] == e.data, "rdata", k, {24'd0, rdata[k]}, {24'd0, e.data});
      end
    end
    if (busy[k] && have_cur[k])
      chk(dir[k] == cur_addr[k], "dir_hold", k, {16'd0, dir[k]}, {16'd0, cur_addr[k]});
    if (!le[k]) begin
      lo_run[k]++;
      chk(cur_we[k], "le_low_not_write", k, 32'd0, 32'd1);
      chk(dv == cur_wd[k], "datos_write", k, {24'd0, dv}, {24'd0, cur_wd[k]});
    end else begin
      if (lo_run[k] != 0) begin
        chk(lo_run[k] == wof(k), "le_low_len", k, lo_run[k], wof(k));
        lo_run[k] = 0;
      end
      chk(dv == mem[k][dir[k]], "bus_contention", k, {24'd0, dv}, {24'd0, mem[k][dir[k]]});
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      monitor_step(0);
      monitor_step(1);
    end
  end

  task automatic issue(input int k, input bit w, input logic [15:0] a, input logic [7:0] d);
    exp_t e;
    int   g;
    g = 0;
    @(negedge clk);
    while (busy[k] && g < 100) begin @(negedge clk); g++; end
    if (g >= 100) chk(1'b0, "issue_timeout", k, g, 100);
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
    @(posedge clk); #1;
    req[k] = 1'b0;
    last_e0[k]  = cyc;
    have_cur[k] = 1'b1;
    cur_addr[k] = a;
    cur_we[k]   = w;
    cur_wd[k]   = d;
    e.rd  = !w;
    e.due = cyc + wof(k) + (w ? 2 : 1);
    if (w) begin
      model[k][a] = d;
      e.data = d;
    end else begin
      e.data = model[k][a];
    end
    if (k == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // Requests made while busy must be ignored.
  task automatic pulse_busy(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy[k]) begin
        req[k] = 1'b1; we[k] = $urandom_range(0, 1) == 1;
        addr[k] = 16'($urandom); wdata[k] = 8'($urandom);
        @(posedge clk); #1;
        req[k] = 1'b0;
      end
    end
  endtask

  task automatic drain(input int k);
    int g;
    g = 0;
    while (qsize(k) != 0 && g < 300) begin @(negedge clk); g++; end
    chk(qsize(k) == 0, "drain_timeout", k, qsize(k), 0);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input int k);
    logic [7:0] dv;
    dv = (k == 0) ? datos0 : datos1;
    chk(le[k] == 1'b1, "rst_le", k, {31'd0, le[k]}, 32'd1);
    chk(dir[k] == 16'h0000, "rst_dir", k, {16'd0, dir[k]}, 32'd0);
    chk(ack[k] == 1'b0, "rst_ack", k, {31'd0, ack[k]}, 32'd0);
    chk(busy[k] == 1'b0, "rst_busy", k, {31'd0, busy[k]}, 32'd0);
    chk(rdata[k] == 8'h00, "rst_rdata", k, {24'd0, rdata[k]}, 32'd0);
    chk(dv == mem[k][16'h0000], "rst_datos_released", k, {24'd0, dv}, {24'd0, mem[k][0]});
  endtask

  task automatic clear_tracking();
    q0.delete(); q1.delete();
    for (int k = 0; k < 2; k++) begin
      have_cur[k] = 1'b0; lo_run[k] = 0;
    end
  endtask

  initial begin
    int e0w;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; addr[k] = 16'h0; wdata[k] = 8'h0;
      have_cur[k] = 1'b0; lo_run[k] = 0; last_e0[k] = 0;
      for (int i = 0; i < 65536; i++) begin
        mem[k][i]   = 8'(i) ^ 8'h5A;
        model[k][i] = 8'(i) ^ 8'h5A;
      end
    end
    mem[1][16'h0010]   = 8'h3C;
    model[1][16'h0010] = 8'h3C;

    #2 rst_n = 1'b0;
    #1 check_reset_outputs(0);
    check_reset_outputs(1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Write then read back, W=1.
    issue(0, 1'b1, 16'h1234, 8'hA5);
    drain(0);
    chk(mem[0][16'h1234] == 8'hA5, "mem_written", 0, {24'd0, mem[0][16'h1234]}, 32'hA5);
    issue(0, 1'b0, 16'h1234, 8'h00);
    drain(0);

    // W=3 read of a preloaded location.
    issue(1, 1'b0, 16'h0010, 8'h00);
    drain(1);

    // Back-to-back write then read in the ack cycle.
    issue(0, 1'b1, 16'h0001, 8'h11);
    e0w = last_e0[0];
    issue(0, 1'b0, 16'h0001, 8'h00);
    chk(last_e0[0] == e0w + W0 + 3, "b2b_gap", 0, last_e0[0], e0w + W0 + 3);
    drain(0);

    // Requests during SETUP / WR_STB / RD_WAIT are ignored.
    issue(1, 1'b1, 16'h0040, 8'h9C);
    pulse_busy(1, 6);
    issue(1, 1'b0, 16'h0040, 8'h00);
    pulse_busy(1, 5);
    drain(1);
    issue(0, 1'b0, 16'h0001, 8'h00);
    pulse_busy(0, 3);
    drain(0);

    // Reset in the middle of a write strobe.
    issue(1, 1'b1, 16'h0020, 8'h77);
    @(posedge clk);
    @(negedge clk);
    chk(le[1] == 1'b0, "le_low_before_rst", 1, {31'd0, le[1]}, 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(1);
    clear_tracking();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk(mem[1][16'h0020] == 8'h77, "mem_after_abort", 1, {24'd0, mem[1][16'h0020]}, 32'h77);
    issue(1, 1'b0, 16'h0020, 8'h00);
    drain(1);

    // Randomized traffic on both widths.
    for (int n = 0; n < 30; n++) begin
      for (int k = 0; k < 2; k++) begin
        issue(k, $urandom_range(0, 1) == 1, 16'h0100 + 16'($urandom_range(0, 15)), 8'($urandom));
        if ($urandom_range(0, 2) == 0) pulse_busy(k, 2);
      end
    end
    drain(0);
    drain(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=%0t exp=<500000", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
